// File: rtl/snax_simbacore_out_packer.sv
// Packs narrow SimbaCore result beats into streamer-width words, zero-padding the final word of a job.
// Optional stall counter enabled by defining SNAX_SIMBACORE_PACKER_PERF_EN.
module snax_simbacore_out_packer #(
    parameter int unsigned InWidth  = 16,
    parameter int unsigned OutWidth = 64,
    parameter int unsigned LenWidth = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [LenWidth-1:0] cfg_len_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [InWidth-1:0]  in_data_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic [OutWidth-1:0] out_data_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                out_last_o,
    output logic                busy_o,
    output logic [31:0]         perf_cnt_o
);

    localparam int unsigned Lanes    = OutWidth / InWidth;
    localparam int unsigned IdxWidth = (Lanes > 1) ? $clog2(Lanes) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StPack  = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [1:0]          state;
    logic [OutWidth-1:0] acc;
    logic [OutWidth-1:0] acc_next;
    logic [IdxWidth-1:0] idx;
    logic [LenWidth-1:0] remaining;
    logic                word_pending;
    logic                pend_last;
    logic [OutWidth-1:0] oreg;
    logic                oreg_valid;
    logic                oreg_last;

    logic beat_fire;
    logic beat_last;
    logic word_done;
    logic oreg_free;

    assign cfg_ready_o = (state == StIdle);
    assign in_ready_o  = (state == StPack) && !word_pending;
    assign busy_o      = (state != StIdle);
    assign out_data_o  = oreg;
    assign out_valid_o = oreg_valid;
    assign out_last_o  = oreg_last;

    assign beat_fire = in_valid_i && in_ready_o;
    assign beat_last = (remaining == LenWidth'(1));
    assign word_done = beat_fire && ((idx == IdxWidth'(Lanes - 1)) || beat_last);
    assign oreg_free = !oreg_valid || out_ready_i;

    // Unwritten lanes of acc are always zero, so a short final word is padded for free.
    always_comb begin
        acc_next = acc;
        for (int k = 0; k < Lanes; k++) begin
            if (idx == IdxWidth'(k)) begin
                acc_next[k*InWidth +: InWidth] = in_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= StIdle;
            acc          <= '0;
            idx          <= '0;
            remaining    <= '0;
            word_pending <= 1'b0;
            pend_last    <= 1'b0;
            oreg         <= '0;
            oreg_valid   <= 1'b0;
            oreg_last    <= 1'b0;
        end else begin
            if (oreg_valid && out_ready_i) begin
                oreg_valid <= 1'b0;
                oreg_last  <= 1'b0;
            end
            case (state)
                StIdle: begin
                    if (cfg_valid_i && (cfg_len_i != '0)) begin
                        remaining <= cfg_len_i;
                        state     <= StPack;
                    end
                end
                StPack: begin
                    // A parked word takes oreg the moment it frees, possibly in the same cycle it drains.
                    if (word_pending) begin
                        if (oreg_free) begin
                            oreg         <= acc;
                            oreg_valid   <= 1'b1;
                            oreg_last    <= pend_last;
                            acc          <= '0;
                            idx          <= '0;
                            word_pending <= 1'b0;
                            if (pend_last) begin
                                state <= StDrain;
                            end
                        end
                    end else if (beat_fire) begin
                        remaining <= remaining - LenWidth'(1);
                        if (word_done) begin
                            if (oreg_free) begin
                                oreg       <= acc_next;
                                oreg_valid <= 1'b1;
                                oreg_last  <= beat_last;
                                acc        <= '0;
                                idx        <= '0;
                                if (beat_last) begin
                                    state <= StDrain;
                                end
                            end else begin
                                acc          <= acc_next;
                                word_pending <= 1'b1;
                                pend_last    <= beat_last;
                            end
                        end else begin
                            acc <= acc_next;
                            idx <= idx + IdxWidth'(1);
                        end
                    end
                end
                StDrain: begin
                    if (oreg_valid && out_ready_i && oreg_last) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef SNAX_SIMBACORE_PACKER_PERF_EN
    logic [31:0] perf_cnt;

    // Counts back-pressure cycles on the output; restarts with each accepted job config.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_cnt <= '0;
        end else if (cfg_valid_i && cfg_ready_o) begin
            perf_cnt <= '0;
        end else if (oreg_valid && !out_ready_i && (perf_cnt != '1)) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign perf_cnt_o = perf_cnt;
`else
    assign perf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_snax_simbacore_out_packer.sv
// Directed self-checking bench for snax_simbacore_out_packer (Lanes = 4, 16-bit beats into 64-bit words).
module tb_snax_simbacore_out_packer;

    localparam int Lanes = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] cfg_len_i;
    logic        cfg_valid_i;
    logic        cfg_ready_o;
    logic [15:0] in_data_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        out_last_o;
    logic        busy_o;
    logic [31:0] perf_cnt_o;

    int vectors     = 0;
    int miscompares = 0;

    snax_simbacore_out_packer #(
        .InWidth (16),
        .OutWidth(64),
        .LenWidth(32)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cfg_len_i  (cfg_len_i),
        .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o),
        .in_data_i  (in_data_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .out_data_o (out_data_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_last_o (out_last_o),
        .busy_o     (busy_o),
        .perf_cnt_o (perf_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_valid"}, 64'(out_valid_o), 64'd0);
        checkOutput({tag, "_last"}, 64'(out_last_o), 64'd0);
        checkOutput({tag, "_data"}, out_data_o, 64'd0);
        checkOutput({tag, "_in_ready"}, 64'(in_ready_o), 64'd0);
        checkOutput({tag, "_cfg_ready"}, 64'(cfg_ready_o), 64'd1);
        checkOutput({tag, "_busy"}, 64'(busy_o), 64'd0);
        checkOutput({tag, "_perf"}, 64'(perf_cnt_o), 64'd0);
    endtask

    // Runs one job of len beats valued base, base+1, ...; optional 6-cycle output stall and cfg poke.
    task automatic applyStimulus(input int len, input int base, input bit stall, input bit poke);
        logic [63:0] exp_words[$];
        logic [63:0] word;
        logic [63:0] prev_data;
        logic        prev_last;
        bit          hold_prev  = 0;
        bit          exp_valid  = 0;
        bit          exp_vnext;
        bit          beat_now;
        bit          stall_used = 0;
        bit          saw_low    = 0;
        int          stall_left = 0;
        int          sent       = 0;
        int          widx       = 0;
        int          nwords     = (len + Lanes - 1) / Lanes;
        int          exp_perf   = 0;

        for (int w = 0; w < nwords; w++) begin
            word = '0;
            for (int l = 0; l < Lanes; l++) begin
                if (w * Lanes + l < len) word[l*16 +: 16] = 16'(base + w * Lanes + l);
            end
            exp_words.push_back(word);
        end

        checkOutput("cfg_ready_idle", 64'(cfg_ready_o), 64'd1);
        cfg_len_i   = 32'(len);
        cfg_valid_i = 1'b1;
        step();
        cfg_valid_i = 1'b0;

        for (int cyc = 0; cyc < 300; cyc++) begin
            if (widx == nwords && !busy_o) break;
            if (stall && !stall_used && out_valid_o) begin
                stall_left = 6;
                stall_used = 1;
            end
            out_ready_i = (stall_left == 0);
            if (stall_left > 0) stall_left--;

            if (hold_prev) begin
                checkOutput("hold_valid", 64'(out_valid_o), 64'd1);
                checkOutput("hold_data", out_data_o, prev_data);
                checkOutput("hold_last", 64'(out_last_o), 64'(prev_last));
            end
            if (!stall) begin
                checkOutput("valid_timing", 64'(out_valid_o), 64'(exp_valid));
                if (sent < len) checkOutput("in_ready", 64'(in_ready_o), 64'd1);
            end
            if (busy_o && !in_ready_o && !out_last_o) saw_low = 1;

            if (poke && sent >= 2 && sent < 5) begin
                cfg_valid_i = 1'b1;
                cfg_len_i   = 32'd99;
                checkOutput("cfg_ready_busy", 64'(cfg_ready_o), 64'd0);
            end else begin
                cfg_valid_i = 1'b0;
            end

            in_valid_i = (sent < len);
            in_data_i  = 16'(base + sent);
            beat_now   = in_valid_i && in_ready_o;
            exp_vnext  = beat_now && (((sent % Lanes) == Lanes - 1) || (sent == len - 1));
            if (beat_now) sent++;

            if (out_valid_o && out_ready_i) begin
                if (widx < nwords) begin
                    checkOutput($sformatf("word%0d", widx), out_data_o, exp_words[widx]);
                    checkOutput($sformatf("last%0d", widx), 64'(out_last_o), 64'(widx == nwords - 1));
                end else begin
                    checkOutput("extra_word", 64'(widx), 64'(nwords));
                end
                widx++;
            end

            hold_prev = out_valid_o && !out_ready_i;
            prev_data = out_data_o;
            prev_last = out_last_o;
            exp_valid = exp_vnext;
            step();
        end

        in_valid_i  = 1'b0;
        cfg_valid_i = 1'b0;
        out_ready_i = 1'b1;
        checkOutput("words_seen", 64'(widx), 64'(nwords));
        checkOutput("beats_sent", 64'(sent), 64'(len));
        checkOutput("idle_after", 64'(busy_o), 64'd0);
        checkOutput("in_ready_drop", 64'(saw_low), 64'(stall));
`ifdef SNAX_SIMBACORE_PACKER_PERF_EN
        if (stall) exp_perf = 6;
`endif
        checkOutput("perf_cnt", 64'(perf_cnt_o), 64'(exp_perf));
    endtask

    initial begin
        rst_i       = 1'b1;
        cfg_len_i   = '0;
        cfg_valid_i = 1'b0;
        in_data_i   = '0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        step();
        step();
        checkReset("reset");
        rst_i = 1'b0;
        step();

        $display("[TB] job len=8, free-flowing output");
        applyStimulus(8, 1, 0, 0);

        $display("[TB] job len=10, padded final word");
        applyStimulus(10, 1, 0, 0);

        $display("[TB] job len=8 with output stall");
        applyStimulus(8, 1, 1, 0);

        $display("[TB] zero-length config");
        cfg_len_i   = 32'd0;
        cfg_valid_i = 1'b1;
        step();
        cfg_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("len0_valid", 64'(out_valid_o), 64'd0);
            checkOutput("len0_busy", 64'(busy_o), 64'd0);
            checkOutput("len0_cfg_ready", 64'(cfg_ready_o), 64'd1);
            step();
        end

        $display("[TB] reset in the middle of a job");
        cfg_len_i   = 32'd8;
        cfg_valid_i = 1'b1;
        step();
        cfg_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("mid_in_ready", 64'(in_ready_o), 64'd1);
            in_valid_i = 1'b1;
            in_data_i  = 16'(16'hAA + i);
            step();
        end
        in_valid_i = 1'b0;
        rst_i      = 1'b1;
        step();
        checkReset("mid_reset");
        rst_i = 1'b0;
        step();
        applyStimulus(4, 'h11, 0, 0);

        $display("[TB] config poke while packing");
        applyStimulus(8, 'h100, 0, 1);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
